vga_sync_gen: RTL

//   VGA raster timing generator sitting directly downstream of the frequency divider.

---
 rtl/vga_sync_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator running on the divider's pixel clock.
// Stage 1 holds the raw h/v counters; stage 2 registers every output decoded
// from the stage-1 values, so all outputs share one cycle of latency and
// change together on the same edge.
// Timing parameters must give totals of at most 1024 so that the 10-bit
// counters and coordinates hold every position on the raster.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 10-bit decode constants; the sync window is [start, end).
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  logic hsync_d;
  logic vsync_d;
  logic video_on_d;
  logic line_start_d;
  logic frame_start_d;
  logic vblank_start_d;

  // Stage 1: raster counters; v advances only when h wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode of the stage-1 position into next output values.
  always_comb begin
    video_on_d     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_d        = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? H_POL : ~H_POL;
    vsync_d        = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? V_POL : ~V_POL;
    line_start_d   = (h_cnt == 10'd0);
    frame_start_d  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    vblank_start_d = (h_cnt == 10'd0) && (v_cnt == V_ACT);
  end

  // Stage 2: register every output so nothing depends combinationally on inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      video_on     <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      hsync        <= hsync_d;
      vsync        <= vsync_d;
      video_on     <= video_on_d;
      pixel_x      <= h_cnt;
      pixel_y      <= v_cnt;
      line_start   <= line_start_d;
      frame_start  <= frame_start_d;
      vblank_start <= vblank_start_d;
    end
  end

endmodule
